my_hack_seq: RTL and testbench

- Multi-cycle control sequencer for the 16-bit Hack CPU datapath.
- Fetches an instruction over a req/ack instruction-memory handshake and latches it in an internal IR.
- Decodes the instruction, then sequences optional data-memory read/write handshakes.
- Drives the program counter (load/inc/reset), A/D register loads, ALU control and A-input select; counts retired instructions.

---
 rtl/my_hack_pkg.sv | 41 ++++
 rtl/my_hack_jump.sv | 23 ++
 rtl/my_hack_seq.sv | 185 ++++++++++++++++++
 tb/tb_my_hack_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/my_hack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : my_hack_pkg
// Description : Shared types and helpers for the Hack CPU control sequencer.
//               Provides the sequencer state encoding, the instruction-register
//               field positions and the jump-condition function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package my_hack_pkg;

    // Sequencer states. RST is 0 so the debug state output reads 0 in reset.
    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MREAD  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_MWRITE = 3'd5
    } state_e;

    // Instruction-register field positions
    localparam int c_ir_type_bit   = 15;  // 0 = A-instruction, 1 = C-instruction
    localparam int c_ir_a_bit      = 12;  // ALU y-input: 0 = A, 1 = M
    localparam int c_ir_comp_msb   = 11;  // zx,nx,zy,ny,f,no
    localparam int c_ir_comp_lsb   = 6;
    localparam int c_ir_dest_a_bit = 5;
    localparam int c_ir_dest_d_bit = 4;
    localparam int c_ir_dest_m_bit = 3;
    localparam int c_ir_jump_msb   = 2;   // j1 (<0), j2 (=0), j3 (>0)
    localparam int c_ir_jump_lsb   = 0;

    // Jump condition from the three jump bits and the ALU status flags.
    function automatic logic jump_taken(input logic [2:0] jbits,
                                        input logic       zr,
                                        input logic       ng);
        return (jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & ~ng & ~zr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/my_hack_jump.sv
`default_nettype none
// ============================================================================
// Module      : my_hack_jump
// Description : Combinational jump-condition evaluator for the Hack sequencer.
// Ports       : jbits [2:0] - IR jump field (j1 j2 j3)
//               zr          - ALU output is zero
//               ng          - ALU output is negative
//               taken       - 1 when the jump condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module my_hack_jump
    import my_hack_pkg::*;
(
    input  logic [2:0] jbits,
    input  logic       zr,
    input  logic       ng,
    output logic       taken
);

    assign taken = jump_taken(jbits, zr, ng);

endmodule
`default_nettype wire

// File: rtl/my_hack_seq.sv
`default_nettype none
// ============================================================================
// Module      : my_hack_seq
// Description : Multi-cycle control sequencer for the 16-bit Hack CPU.
//               Fetches over an imem req/ack handshake, decodes, runs optional
//               data-memory read/write handshakes and commits register, PC and
//               retired-instruction updates.
// Ports       : clk, reset_n (async, active low), run (fetch gate)
//               imem_req/imem_ack/imem_data  - instruction fetch handshake
//               dmem_req/dmem_we/dmem_ack    - data memory handshake
//               alu_zr/alu_ng                - ALU status flags
//               alu_ctl/alu_y_sel            - ALU control from IR
//               a_load/a_sel/d_load          - register load controls
//               ir_out                       - current IR
//               pc_reset/pc_load/pc_inc      - program counter controls
//               retired                      - retired instruction count
//               state                        - debug view of sequencer state
// Revision    : 1.0 - initial release
// ============================================================================
module my_hack_seq
    import my_hack_pkg::*;
#(
    parameter int PERF_CNT_W = 32
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    output logic                  imem_req,
    input  logic                  imem_ack,
    input  logic [15:0]           imem_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ack,
    input  logic                  alu_zr,
    input  logic                  alu_ng,
    output logic [5:0]            alu_ctl,
    output logic                  alu_y_sel,
    output logic                  a_load,
    output logic                  a_sel,
    output logic                  d_load,
    output logic [15:0]           ir_out,
    output logic                  pc_reset,
    output logic                  pc_load,
    output logic                  pc_inc,
    output logic [PERF_CNT_W-1:0] retired,
    output logic [2:0]            state
);

    state_e                  state_q, state_d;
    logic [15:0]             ir_q, ir_d;
    logic [PERF_CNT_W-1:0]   retired_q, retired_d;
    logic                    jump;
    logic                    commit;
    logic                    retire;

    my_hack_jump u_jump (
        .jbits (ir_q[c_ir_jump_msb:c_ir_jump_lsb]),
        .zr    (alu_zr),
        .ng    (alu_ng),
        .taken (jump)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RST;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                // The ack only counts while a request is actually out.
                if (run && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!ir_q[c_ir_type_bit])
                    state_d = ST_FETCH;
                else if (ir_q[c_ir_a_bit])
                    state_d = ST_MREAD;
                else
                    state_d = ST_EXEC;
            end
            ST_MREAD: begin
                if (dmem_ack)
                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ir_q[c_ir_dest_m_bit] ? ST_MWRITE : ST_FETCH;
            end
            ST_MWRITE: begin
                if (dmem_ack)
                    state_d = ST_FETCH;
            end
            default: state_d = ST_RST;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_ctl   = '0;
        alu_y_sel = 1'b0;
        a_load    = 1'b0;
        a_sel     = 1'b0;
        d_load    = 1'b0;
        pc_reset  = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        commit    = 1'b0;
        retire    = 1'b0;

        unique case (state_q)
            // Gated by reset_n so every output is 0 while reset is held.
            ST_RST:   pc_reset = reset_n;
            ST_FETCH: imem_req = run;
            ST_DECODE: begin
                if (!ir_q[c_ir_type_bit]) begin
                    a_load = 1'b1;
                    pc_inc = 1'b1;
                    retire = 1'b1;
                end
            end
            ST_MREAD: begin
                dmem_req  = 1'b1;
                alu_ctl   = ir_q[c_ir_comp_msb:c_ir_comp_lsb];
                alu_y_sel = ir_q[c_ir_a_bit];
            end
            ST_EXEC: begin
                alu_ctl   = ir_q[c_ir_comp_msb:c_ir_comp_lsb];
                alu_y_sel = ir_q[c_ir_a_bit];
                // A memory destination defers the whole commit to MWRITE.
                commit    = ~ir_q[c_ir_dest_m_bit];
            end
            ST_MWRITE: begin
                dmem_req  = 1'b1;
                dmem_we   = 1'b1;
                alu_ctl   = ir_q[c_ir_comp_msb:c_ir_comp_lsb];
                alu_y_sel = ir_q[c_ir_a_bit];
                commit    = dmem_ack;
            end
            default: ;
        endcase

        // PC load and register loads share one edge, so a jump uses the
        // A value from before this commit.
        if (commit) begin
            a_load  = ir_q[c_ir_dest_a_bit];
            a_sel   = 1'b1;
            d_load  = ir_q[c_ir_dest_d_bit];
            pc_load = jump;
            pc_inc  = ~jump;
            retire  = 1'b1;
        end

        retired_d = retire ? retired_q + PERF_CNT_W'(1) : retired_q;
    end

    assign ir_out  = ir_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_my_hack_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_hack_seq
// Description : Self-checking bench for my_hack_seq. Applies directed and
//               random instructions with random handshake delays and compares
//               every cycle against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_my_hack_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        alu_zr;
    logic        alu_ng;
    logic [5:0]  alu_ctl;
    logic        alu_y_sel;
    logic        a_load;
    logic        a_sel;
    logic        d_load;
    logic [15:0] ir_out;
    logic        pc_reset;
    logic        pc_load;
    logic        pc_inc;
    logic [31:0] retired;
    logic [2:0]  state;

    my_hack_seq #(.PERF_CNT_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .alu_zr    (alu_zr),
        .alu_ng    (alu_ng),
        .alu_ctl   (alu_ctl),
        .alu_y_sel (alu_y_sel),
        .a_load    (a_load),
        .a_sel     (a_sel),
        .d_load    (d_load),
        .ir_out    (ir_out),
        .pc_reset  (pc_reset),
        .pc_load   (pc_load),
        .pc_inc    (pc_inc),
        .retired   (retired),
        .state     (state)
    );

    always #5 clk = ~clk;

    logic [15:0] ctl_obs;
    assign ctl_obs = {imem_req, dmem_req, dmem_we, a_load, a_sel, d_load,
                      pc_load, pc_inc, pc_reset, alu_y_sel, alu_ctl};

    // Reference model state
    logic [31:0] retired_m;
    logic [15:0] ir_m;
    int          cyc_cnt;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control vector, same bit order as ctl_obs.
    function automatic logic [15:0] ev(input bit ireq, input bit dreq, input bit we,
                                       input bit al, input bit asl, input bit dl,
                                       input bit pl, input bit pi, input bit pr,
                                       input logic [6:0] alu);
        return {ireq, dreq, we, al, asl, dl, pl, pi, pr, alu};
    endfunction

    // One clock: check at negedge, advance past posedge, apply model update.
    task automatic do_cycle(input logic [15:0] exp, input bit bump);
        @(negedge clk);
        chk("ctl", {16'h0, ctl_obs}, {16'h0, exp});
        chk("retired", retired, retired_m);
        chk("ir", {16'h0, ir_out}, {16'h0, ir_m});
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (bump) retired_m++;
    endtask

    // Run one instruction from FETCH to its retirement.
    // cls: ALU result class 0 = negative, 1 = zero, 2 = positive.
    task automatic exec_instr(input logic [15:0] ir, input int fw, input int rw,
                              input int ww, input int cls, input int stall);
        logic [6:0]  alu;
        logic [15:0] cv;
        bit          jmp;
        int          start;
        int          lat;

        alu_zr = (cls == 1);
        alu_ng = (cls == 0);

        // Stalled fetch: acks and data must be ignored.
        run = 1'b0;
        for (int k = 0; k < stall; k++) begin
            imem_ack  = 1'($urandom);
            imem_data = 16'($urandom);
            dmem_ack  = 1'($urandom);
            do_cycle(16'h0000, 1'b0);
        end

        start = cyc_cnt;
        run   = 1'b1;
        for (int k = 0; k <= fw; k++) begin
            imem_ack  = (k == fw);
            imem_data = (k == fw) ? ir : 16'($urandom);
            dmem_ack  = 1'($urandom);
            do_cycle(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'h0), 1'b0);
        end
        ir_m      = ir;
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        dmem_ack  = 1'b0;
        run       = 1'($urandom);   // must not affect an instruction in flight

        // Jump bit selected by the result class: bit2 <0, bit1 =0, bit0 >0.
        jmp = ir[2 - cls];
        alu = {ir[12], ir[11:6]};
        cv  = ev(0, 0, 0, ir[5], 1, ir[4], jmp, !jmp, 0, alu);

        if (!ir[15]) begin
            do_cycle(ev(0, 0, 0, 1, 0, 0, 0, 1, 0, 7'h0), 1'b1);
            lat = 2 + fw;
        end else begin
            do_cycle(16'h0000, 1'b0);
            lat = 3 + fw;
            if (ir[12]) begin
                for (int k = 0; k <= rw; k++) begin
                    dmem_ack = (k == rw);
                    do_cycle(ev(0, 1, 0, 0, 0, 0, 0, 0, 0, alu), 1'b0);
                end
                dmem_ack = 1'b0;
                lat += 1 + rw;
            end
            if (ir[3]) begin
                do_cycle(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, alu), 1'b0);
                for (int k = 0; k <= ww; k++) begin
                    dmem_ack = (k == ww);
                    if (k == ww)
                        do_cycle(cv | ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 7'h0), 1'b1);
                    else
                        do_cycle(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, alu), 1'b0);
                end
                dmem_ack = 1'b0;
                lat += 1 + ww;
            end else begin
                do_cycle(cv, 1'b1);
            end
        end
        chk("latency", 32'(cyc_cnt - start), 32'(lat));
        run = 1'b1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc_cnt   = 0;
        retired_m = '0;
        ir_m      = '0;
        reset_n   = 1'b0;
        run       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        dmem_ack  = 1'b0;
        alu_zr    = 1'b0;
        alu_ng    = 1'b0;

        // Reset state
        #2;
        chk("rst_ctl", {16'h0, ctl_obs}, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_ir", {16'h0, ir_out}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run     = 1'b1;
        do_cycle(ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'h0), 1'b0);  // single pc_reset

        // Directed cases
        exec_instr(16'h0005, 0, 0, 0, 2, 0);   // A-instruction
        exec_instr(16'hEC10, 0, 0, 0, 2, 0);   // D=A
        exec_instr(16'hFC88, 0, 3, 2, 2, 0);   // M=M-1 with delayed acks
        exec_instr(16'hE302, 0, 0, 0, 1, 0);   // D;JEQ taken
        exec_instr(16'hE302, 0, 0, 0, 2, 0);   // D;JEQ not taken
        exec_instr(16'h1234, 2, 0, 0, 0, 4);   // stall with stray acks, then resume

        // Random instructions
        for (int i = 0; i < 120; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if ($urandom_range(0, 2) == 0) r[15] = 1'b0;
            else                           r[15] = 1'b1;
            exec_instr(r, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 2),
                       ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Reset while MWRITE waits for its ack
        alu_zr = 1'b0;
        alu_ng = 1'b0;
        run    = 1'b1;
        imem_ack = 1'b1; imem_data = 16'hFC88;
        do_cycle(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'h0), 1'b0);
        ir_m = 16'hFC88;
        imem_ack = 1'b0;
        do_cycle(16'h0000, 1'b0);
        dmem_ack = 1'b1;
        do_cycle(ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 7'h72), 1'b0);
        dmem_ack = 1'b0;
        do_cycle(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'h72), 1'b0);
        do_cycle(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 7'h72), 1'b0);
        #2;
        reset_n  = 1'b0;
        dmem_ack = 1'b1;
        imem_ack = 1'b1;
        #1;
        chk("arst_ctl", {16'h0, ctl_obs}, 32'h0);
        chk("arst_retired", retired, 32'h0);
        chk("arst_ir", {16'h0, ir_out}, 32'h0);
        chk("arst_state", {29'h0, state}, 32'h0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        dmem_ack  = 1'b0;
        imem_ack  = 1'b0;
        retired_m = '0;
        ir_m      = '0;
        do_cycle(ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'h0), 1'b0);
        exec_instr(16'h7FFF, 1, 0, 0, 0, 0);
        exec_instr(16'hF1CF, 0, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
